// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state codes and transaction owner codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection: LS wins contention unless IF has been starved long enough.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       starved,
    output logic       pick_valid,
    output arb_owner_t pick_owner
);

    always_comb begin
        pick_valid = if_req | ls_req;
        pick_owner = OWN_IF;
        if (ls_req && !(if_req && starved)) begin
            pick_owner = OWN_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// LS has priority; a saturating streak counter forces an IF grant after STARVE_LIMIT LS wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                err
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q;
    arb_state_t            state_d;
    arb_owner_t            owner_q;
    arb_owner_t            pick_owner;
    logic                  pick_valid;
    logic                  accept;
    logic [STREAK_W-1:0]   streak_q;
    logic                  starved;

    assign starved = (streak_q == STREAK_W'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starved    (starved),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    // Grants must land in the accept cycle itself, so they are decoded from the registered state.
    assign accept = (state_q == ARB_REQ) && mem_req && mem_ready;
    assign if_gnt = accept && (owner_q == OWN_IF);
    assign ls_gnt = accept && (owner_q == OWN_LS);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (pick_valid) state_d = ARB_REQ;
            ARB_REQ:  if (accept)     state_d = ARB_RESP;
            ARB_RESP: if (mem_rvalid) state_d = ARB_IDLE;
            default:                  state_d = ARB_IDLE;
        endcase
    end

    // Datapath: latch the winner's fields on pick, release the bus on accept, route the response.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_IF;
            streak_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            busy      <= (state_d != ARB_IDLE);
            if (mem_rvalid && (state_q != ARB_RESP)) begin
                err <= 1'b1;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_owner;
                        mem_req <= 1'b1;
                        if (pick_owner == OWN_LS) begin
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_wstrb <= ls_we ? ls_wstrb : '0;
                            if (!if_req) begin
                                streak_q <= '0;
                            end else if (!starved) begin
                                streak_q <= streak_q + STREAK_W'(1);
                            end
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                            streak_q  <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    if (accept) begin
                        mem_req   <= 1'b0;
                        mem_wstrb <= '0;
                    end
                end
                ARB_RESP: begin
                    if (mem_rvalid) begin
                        if (owner_q == OWN_LS) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bus model answers one cycle after accept.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [STRB_W-1:0] ls_wstrb;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              err;

    logic [DATA_W-1:0] resp_data;
    int                tests_run = 0;
    int                tests_failed = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_wstrb   (ls_wstrb),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err        (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock; the bus answers in the cycle after an accept, then outputs settle.
    task automatic applyStimulus();
        logic accepted;
        accepted = mem_req && mem_ready;
        @(posedge clock);
        #1;
        mem_rvalid = 1'b0;
        if (accepted) begin
            mem_rvalid = 1'b1;
            mem_rdata  = resp_data;
        end
        #1;
    endtask

    task automatic doIfRead(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if_req    = 1'b1;
        if_addr   = addr;
        resp_data = data;
        #1;
        applyStimulus();
        checkOutput({tag, " mem_req c1"}, 64'(mem_req), 64'd1);
        checkOutput({tag, " mem_addr c1"}, 64'(mem_addr), 64'(addr));
        checkOutput({tag, " if_gnt c1"}, 64'(if_gnt), 64'd1);
        checkOutput({tag, " ls_gnt c1"}, 64'(ls_gnt), 64'd0);
        if_req = 1'b0;
        applyStimulus();
        checkOutput({tag, " if_rvalid c2"}, 64'(if_rvalid), 64'd0);
        checkOutput({tag, " mem_req c2"}, 64'(mem_req), 64'd0);
        applyStimulus();
        checkOutput({tag, " if_rvalid c3"}, 64'(if_rvalid), 64'd1);
        checkOutput({tag, " if_rdata c3"}, 64'(if_rdata), 64'(data));
        checkOutput({tag, " ls_rvalid c3"}, 64'(ls_rvalid), 64'd0);
    endtask

    logic [4:0] grant_seq;
    int         grants;
    int         wait_cycles;

    initial begin
        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = '0;
        ls_wdata   = '0;
        ls_wstrb   = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        resp_data  = '0;
        #3;
        checkOutput("reset mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset if_gnt", 64'(if_gnt), 64'd0);
        checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        doIfRead("t1", 64'h8000_0000, 64'h0000_0013);
        checkOutput("t1 busy after", 64'(busy), 64'd0);

        // Stalled store: bus fields must stay frozen until mem_ready rises.
        mem_ready = 1'b0;
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_addr   = 64'h100;
        ls_wdata  = 64'hDEAD;
        ls_wstrb  = 8'h0F;
        #1;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus();
            checkOutput($sformatf("t2 mem_req c%0d", c), 64'(mem_req), 64'd1);
            checkOutput($sformatf("t2 mem_we c%0d", c), 64'(mem_we), 64'd1);
            checkOutput($sformatf("t2 mem_addr c%0d", c), 64'(mem_addr), 64'h100);
            checkOutput($sformatf("t2 mem_wstrb c%0d", c), 64'(mem_wstrb), 64'h0F);
            checkOutput($sformatf("t2 ls_gnt c%0d", c), 64'(ls_gnt), 64'd0);
            checkOutput($sformatf("t2 busy c%0d", c), 64'(busy), 64'd1);
        end
        applyStimulus();
        mem_ready = 1'b1;
        #1;
        checkOutput("t2 ls_gnt accept", 64'(ls_gnt), 64'd1);
        checkOutput("t2 mem_wdata accept", 64'(mem_wdata), 64'hDEAD);
        ls_req = 1'b0;
        ls_we  = 1'b0;
        applyStimulus();
        checkOutput("t2 mem_req after accept", 64'(mem_req), 64'd0);
        checkOutput("t2 mem_wstrb after accept", 64'(mem_wstrb), 64'd0);
        checkOutput("t2 ls_rvalid early", 64'(ls_rvalid), 64'd0);
        applyStimulus();
        checkOutput("t2 ls_rvalid", 64'(ls_rvalid), 64'd1);
        checkOutput("t2 if_rvalid", 64'(if_rvalid), 64'd0);

        // Continuous contention: LS x4, then the starvation guard forces IF, then LS again.
        if_req    = 1'b1;
        if_addr   = 64'h8000_0040;
        ls_req    = 1'b1;
        ls_addr   = 64'h300;
        resp_data = 64'h55;
        grant_seq = '0;
        grants    = 0;
        #1;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            applyStimulus();
            if (if_gnt || ls_gnt) begin
                if (grants < 5) grant_seq[grants] = ls_gnt;
                if (if_gnt) checkOutput("t3 if grant addr", 64'(mem_addr), 64'h8000_0040);
                grants++;
            end
        end
        checkOutput("t3 grant count", 64'(grants), 64'd6);
        checkOutput("t3 grant order", 64'(grant_seq), 64'b01111);
        checkOutput("t3 sixth grant is ls", 64'(ls_gnt), 64'd1);
        if_req = 1'b0;
        ls_req = 1'b0;
        wait_cycles = 0;
        do begin
            applyStimulus();
            wait_cycles++;
        end while (busy && wait_cycles < 10);
        checkOutput("t3 drain idle", 64'(busy), 64'd0);

        // Spurious response in IDLE: flagged, never routed, and traffic still works.
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hBAD;
        #1;
        applyStimulus();
        checkOutput("t4 err set", 64'(err), 64'd1);
        checkOutput("t4 if_rvalid", 64'(if_rvalid), 64'd0);
        checkOutput("t4 ls_rvalid", 64'(ls_rvalid), 64'd0);
        checkOutput("t4 busy", 64'(busy), 64'd0);
        doIfRead("t4", 64'h8000_0008, 64'h1234_5678);
        checkOutput("t4 err sticky", 64'(err), 64'd1);

        // Reset while waiting for a response.
        if_req    = 1'b1;
        if_addr   = 64'h8000_0010;
        resp_data = 64'h77;
        #1;
        applyStimulus();
        if_req = 1'b0;
        applyStimulus();
        checkOutput("t5 busy in resp", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5 async busy", 64'(busy), 64'd0);
        checkOutput("t5 async err", 64'(err), 64'd0);
        checkOutput("t5 async mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("t5 async if_gnt", 64'(if_gnt), 64'd0);
        mem_rvalid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("t5 if_rvalid in reset", 64'(if_rvalid), 64'd0);
        rst_n = 1'b1;
        applyStimulus();
        doIfRead("t5", 64'h8000_0020, 64'h0000_0093);

        // Load under IF contention: full-width data to LS only, then IF is served.
        if_req    = 1'b1;
        if_addr   = 64'h8000_0030;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_addr   = 64'h200;
        ls_wstrb  = 8'hFF;
        resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        applyStimulus();
        checkOutput("t6 ls_gnt", 64'(ls_gnt), 64'd1);
        checkOutput("t6 if_gnt", 64'(if_gnt), 64'd0);
        checkOutput("t6 mem_we", 64'(mem_we), 64'd0);
        checkOutput("t6 mem_wstrb load", 64'(mem_wstrb), 64'd0);
        checkOutput("t6 mem_addr", 64'(mem_addr), 64'h200);
        ls_req = 1'b0;
        applyStimulus();
        resp_data = 64'h0000_0000_0000_0067;
        applyStimulus();
        checkOutput("t6 ls_rvalid", 64'(ls_rvalid), 64'd1);
        checkOutput("t6 ls_rdata", 64'(ls_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t6 if_rvalid", 64'(if_rvalid), 64'd0);
        applyStimulus();
        checkOutput("t6 if served next", 64'(if_gnt), 64'd1);
        checkOutput("t6 if mem_addr", 64'(mem_addr), 64'h8000_0030);
        if_req = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("t6 if_rvalid after", 64'(if_rvalid), 64'd1);
        checkOutput("t6 if_rdata", 64'(if_rdata), 64'h67);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
